// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single physical memory controller
// Data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic [31:0] instr_data,
   output logic        instr_ready,
   input  logic        data_req,
   input  logic        data_is_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ready,
   output logic        dev_mem_start,
   output logic [31:0] dev_mem_addr,
   output logic [31:0] dev_mem_data_out,
   output logic        dev_mem_is_write,
   input  logic [31:0] dev_mem_data_in,
   input  logic        dev_mem_busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t     state;
   logic       owner_instr;
   logic [2:0] starve_cnt;
   logic       grant_data;
   logic       grant_instr;

   always_comb begin
      grant_data  = 1'b0;
      grant_instr = 1'b0;
      if (data_req && !(instr_req && starve_cnt == LIMIT))
         grant_data = 1'b1;
      else if (instr_req)
         grant_instr = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         owner_instr      <= 1'b0;
         starve_cnt       <= 3'd0;
         instr_data       <= 32'd0;
         instr_ready      <= 1'b0;
         data_rdata       <= 32'd0;
         data_ready       <= 1'b0;
         dev_mem_start    <= 1'b0;
         dev_mem_addr     <= 32'd0;
         dev_mem_data_out <= 32'd0;
         dev_mem_is_write <= 1'b0;
      end else begin
         dev_mem_start <= 1'b0;
         instr_ready   <= 1'b0;
         data_ready    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_data) begin
                  owner_instr      <= 1'b0;
                  dev_mem_addr     <= data_addr;
                  dev_mem_data_out <= data_wdata;
                  dev_mem_is_write <= data_is_write;
                  dev_mem_start    <= 1'b1;
                  state            <= ISSUE;
                  // Only a loss while the fetch port is actually waiting counts as starvation
                  if (instr_req && starve_cnt < LIMIT)
                     starve_cnt <= starve_cnt + 3'd1;
               end else if (grant_instr) begin
                  owner_instr      <= 1'b1;
                  dev_mem_addr     <= instr_addr;
                  dev_mem_data_out <= 32'd0;
                  dev_mem_is_write <= 1'b0;
                  dev_mem_start    <= 1'b1;
                  starve_cnt       <= 3'd0;
                  state            <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (!dev_mem_busy) begin
                  if (owner_instr) begin
                     instr_data  <= dev_mem_data_in;
                     instr_ready <= 1'b1;
                  end else begin
                     if (!dev_mem_is_write)
                        data_rdata <= dev_mem_data_in;
                     data_ready <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Stimulus pushes expected memory transactions and responses; a negedge monitor pops and compares.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic [31:0] instr_data;
   logic        instr_ready;
   logic        data_req;
   logic        data_is_write;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_ready;
   logic        dev_mem_start;
   logic [31:0] dev_mem_addr;
   logic [31:0] dev_mem_data_out;
   logic        dev_mem_is_write;
   logic [31:0] dev_mem_data_in;
   logic        dev_mem_busy;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_data(instr_data), .instr_ready(instr_ready),
      .data_req(data_req), .data_is_write(data_is_write),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_ready(data_ready),
      .dev_mem_start(dev_mem_start), .dev_mem_addr(dev_mem_addr),
      .dev_mem_data_out(dev_mem_data_out), .dev_mem_is_write(dev_mem_is_write),
      .dev_mem_data_in(dev_mem_data_in), .dev_mem_busy(dev_mem_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        is_write;
      logic [31:0] wdata;
      logic [2:0]  starve;
   } dev_exp_t;

   typedef struct {
      logic        is_instr;
      logic [31:0] data;
   } resp_exp_t;

   dev_exp_t  dev_q[$];
   resp_exp_t resp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int busy_cycles = 0;
   int busy_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return a * 3 + 32'h1111;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory controller model: busy rises the cycle after start and lasts busy_cycles cycles
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt     = 0;
         dev_mem_busy = 1'b0;
      end else if (dev_mem_start) begin
         busy_cnt        = busy_cycles;
         dev_mem_busy    = 1'b0;
         dev_mem_data_in = dev_mem_is_write ? 32'hBAD0BAD0 : memfn(dev_mem_addr);
      end else begin
         dev_mem_busy = (busy_cnt > 0);
         if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (dev_mem_start) begin
            if (dev_q.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               dev_exp_t e;
               e = dev_q.pop_front();
               chk("dev_addr", dev_mem_addr, e.addr);
               chk("dev_is_write", {31'd0, dev_mem_is_write}, {31'd0, e.is_write});
               if (e.is_write) chk("dev_data_out", dev_mem_data_out, e.wdata);
               chk("starve_cnt", {29'd0, dut.starve_cnt}, {29'd0, e.starve});
            end
         end
         if (instr_ready || data_ready) begin
            chk("ready_exclusive", {31'd0, instr_ready & data_ready}, 32'd0);
            if (resp_q.size() == 0) begin
               chk("unexpected_ready", 1, 0);
            end else begin
               resp_exp_t r;
               r = resp_q.pop_front();
               chk("ready_port", {31'd0, instr_ready}, {31'd0, r.is_instr});
               if (r.is_instr) chk("instr_data", instr_data, r.data);
               else            chk("data_rdata", data_rdata, r.data);
            end
         end
      end
   end

   task automatic fetch(input logic [31:0] a);
      instr_req  = 1'b1;
      instr_addr = a;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (instr_ready) return;
      end
      chk("instr_timeout", 1, 0);
   endtask

   task automatic data_acc(input logic w, input logic [31:0] a, input logic [31:0] wd);
      data_req      = 1'b1;
      data_is_write = w;
      data_addr     = a;
      data_wdata    = wd;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (data_ready) return;
      end
      chk("data_timeout", 1, 0);
   endtask

   function automatic void push_dev(input logic [31:0] a, input logic w,
                                    input logic [31:0] wd, input logic [2:0] s);
      dev_exp_t e;
      e.addr = a; e.is_write = w; e.wdata = wd; e.starve = s;
      dev_q.push_back(e);
   endfunction

   function automatic void push_resp(input logic is_i, input logic [31:0] d);
      resp_exp_t r;
      r.is_instr = is_i; r.data = d;
      resp_q.push_back(r);
   endfunction

   initial begin
      int c0;
      rst = 1'b1;
      instr_req = 1'b0; instr_addr = '0;
      data_req = 1'b0; data_is_write = 1'b0; data_addr = '0; data_wdata = '0;
      dev_mem_data_in = '0; dev_mem_busy = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_start", {31'd0, dev_mem_start}, 32'd0);
      chk("rst_addr", dev_mem_addr, 32'd0);
      chk("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
      chk("rst_instr_data", instr_data, 32'd0);
      chk("rst_data_rdata", data_rdata, 32'd0);

      // Fetch 0x100 with 2 busy cycles, requested on the cycle reset drops
      busy_cycles = 2;
      push_dev(32'h100, 1'b0, 32'h0, 3'd0);
      push_resp(1'b1, 32'hDEADBEEF);
      rst = 1'b0;
      c0 = cyc;
      fetch(32'h100);
      chk("fetch_latency", cyc - c0 + 1, 6);
      instr_req = 1'b0;
      repeat (2) @(negedge clk);

      // Simultaneous fetch and data read: data first, then fetch
      busy_cycles = 1;
      push_dev(32'h200, 1'b0, 32'h0, 3'd1);
      push_dev(32'h300, 1'b0, 32'h0, 3'd0);
      push_resp(1'b0, 32'h00001711);
      push_resp(1'b1, 32'h00001A11);
      fork
         begin fetch(32'h300); instr_req = 1'b0; end
         begin data_acc(1'b0, 32'h200, 32'h0); data_req = 1'b0; end
      join
      repeat (2) @(negedge clk);

      // Write: rdata keeps the previous read value, minimum latency
      busy_cycles = 0;
      push_dev(32'h40, 1'b1, 32'h12345678, 3'd0);
      push_resp(1'b0, 32'h00001711);
      c0 = cyc;
      data_acc(1'b1, 32'h40, 32'h12345678);
      chk("write_latency", cyc - c0 + 1, 4);
      data_req = 1'b0;
      repeat (2) @(negedge clk);

      // Continuous contention: D,D,D,D,I,D,D,D,D,I
      busy_cycles = 1;
      for (int k = 0; k < 4; k++) begin
         push_dev(32'h2000 + 4 * k, 1'b0, 32'h0, 3'(k + 1));
         push_resp(1'b0, 32'h7111 + 12 * k);
      end
      push_dev(32'h1000, 1'b0, 32'h0, 3'd0);
      push_resp(1'b1, 32'h00004111);
      for (int k = 4; k < 8; k++) begin
         push_dev(32'h2000 + 4 * k, 1'b0, 32'h0, 3'(k - 3));
         push_resp(1'b0, 32'h7111 + 12 * k);
      end
      push_dev(32'h1004, 1'b0, 32'h0, 3'd0);
      push_resp(1'b1, 32'h0000411D);
      fork
         begin fetch(32'h1000); fetch(32'h1004); instr_req = 1'b0; end
         begin
            for (int k = 0; k < 8; k++) data_acc(1'b0, 32'h2000 + 4 * k, 32'h0);
            data_req = 1'b0;
         end
      join
      repeat (2) @(negedge clk);

      // Reset in WAIT abandons the read with no ready pulse
      busy_cycles = 3;
      push_dev(32'h500, 1'b0, 32'h0, 3'd0);
      data_req = 1'b1; data_is_write = 1'b0; data_addr = 32'h500;
      for (int i = 0; i < 20 && !dev_mem_start; i++) @(negedge clk);
      chk("start_seen", {31'd0, dev_mem_start}, 32'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rstw_addr", dev_mem_addr, 32'd0);
      chk("rstw_start", {31'd0, dev_mem_start}, 32'd0);
      chk("rstw_data_ready", {31'd0, data_ready}, 32'd0);
      chk("rstw_data_rdata", data_rdata, 32'd0);
      chk("rstw_instr_data", instr_data, 32'd0);
      data_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      busy_cycles = 0;
      push_dev(32'h100, 1'b0, 32'h0, 3'd0);
      push_resp(1'b1, 32'hDEADBEEF);
      fetch(32'h100);
      instr_req = 1'b0;
      repeat (5) @(negedge clk);

      chk("dev_q_empty", dev_q.size(), 0);
      chk("resp_q_empty", resp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
